// File: rtl/edge_bit_timer.sv
// edge_bit_timer: bit/frame timing generator.
// A frame of F bits is timed, each bit lasting P clocks. P and F are latched
// from PRESCALE/FRAME_BITS when a frame starts and held until the block
// returns to IDLE. Edge_Cnt counts clocks within a bit, Bit_Cnt counts bits.
// Bit_Done and Frame_Done are one-cycle pulses. Cfg_Err flags a run request
// made with an unusable configuration.
// Optional feature: define EDGE_BIT_TIMER_SAMPLE3_EN for three mid-bit sample
// strobes (majority vote). Otherwise only the centre strobe Sample_Stb[1] is
// generated and Sample_Stb[0]/[2] are tied low.
module edge_bit_timer #(
  parameter int PRESC_W = 6,
  parameter int BIT_W   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [PRESC_W-1:0] PRESCALE,
  input  logic [BIT_W-1:0]   FRAME_BITS,
  output logic [PRESC_W-1:0] Edge_Cnt,
  output logic [BIT_W-1:0]   Bit_Cnt,
  output logic [2:0]         Sample_Stb,
  output logic               Bit_Done,
  output logic               Frame_Done,
  output logic               Cfg_Err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [PRESC_W-1:0] r_edge;
  logic [BIT_W-1:0]   r_bit;
  logic [PRESC_W-1:0] r_p;
  logic [BIT_W-1:0]   r_f;
  logic               r_bit_done;
  logic               r_frame_done;
  logic               r_cfg_err;

  logic               w_cfg_ok;
  logic [PRESC_W-1:0] w_p_m1;
  logic [BIT_W-1:0]   w_f_m1;
  logic [PRESC_W-1:0] w_half;
  logic               w_wrap;
  logic               w_last;

  // Live configuration check; only consulted while idle with a run request.
  assign w_cfg_ok = (PRESCALE >= PRESC_W'(4)) && (FRAME_BITS != '0);

  // Terminal counts are compared against P-1 / F-1 so that the counters never
  // need one extra bit of headroom, even with PRESCALE at its maximum.
  assign w_p_m1 = r_p - PRESC_W'(1);
  assign w_f_m1 = r_f - BIT_W'(1);
  assign w_wrap = (r_edge == w_p_m1);
  assign w_last = (r_bit == w_f_m1);
  assign w_half = r_p >> 1;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; dropping EN aborts from any state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (EN && w_cfg_ok) begin
          w_next = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!EN) begin
          w_next = S_IDLE;
        end else if (w_wrap && w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!EN) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Counters, configuration latches and registered pulses/flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge       <= '0;
      r_bit        <= '0;
      r_p          <= '0;
      r_f          <= '0;
      r_bit_done   <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_bit_done   <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= (r_state == S_IDLE) && EN && !w_cfg_ok;
      case (r_state)
        S_IDLE: begin
          r_edge <= '0;
          r_bit  <= '0;
          if (EN && w_cfg_ok) begin
            r_p <= PRESCALE;
            r_f <= FRAME_BITS;
          end
        end
        S_COUNT: begin
          if (!EN) begin
            // Aborted frame: no Frame_Done.
            r_edge <= '0;
            r_bit  <= '0;
          end else if (w_wrap) begin
            r_edge       <= '0;
            r_bit        <= r_bit + BIT_W'(1);
            r_bit_done   <= 1'b1;
            r_frame_done <= w_last;
          end else begin
            r_edge <= r_edge + PRESC_W'(1);
          end
        end
        S_DONE: begin
          // Counters hold the final position until EN is released.
          if (!EN) begin
            r_edge <= '0;
            r_bit  <= '0;
          end
        end
        default: begin
          r_edge <= '0;
          r_bit  <= '0;
        end
      endcase
    end
  end

  // Sample strobes decoded from registered state, active only while counting.
  always_comb begin
    Sample_Stb = 3'b000;
    if (r_state == S_COUNT) begin
`ifdef EDGE_BIT_TIMER_SAMPLE3_EN
      Sample_Stb[0] = (r_edge == (w_half - PRESC_W'(2)));
      Sample_Stb[2] = (r_edge == w_half);
`endif
      Sample_Stb[1] = (r_edge == (w_half - PRESC_W'(1)));
    end
  end

  assign Edge_Cnt   = r_edge;
  assign Bit_Cnt    = r_bit;
  assign Bit_Done   = r_bit_done;
  assign Frame_Done = r_frame_done;
  assign Cfg_Err    = r_cfg_err;

endmodule

// File: doc/edge_bit_timer.md
EDGE_BIT_TIMER -- requirements
Module: edge_bit_timer

Interface
REQ-001 Parameter PRESC_W, default 6, width of the prescale and edge counter.
REQ-002 Parameter BIT_W, default 4, width of the frame-length and bit counter.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 EN  input  1  run request; high = time a frame, low = abort/idle.
REQ-006 PRESCALE  input  PRESC_W  clocks per bit; valid range 4..2^PRESC_W-1.
REQ-007 FRAME_BITS  input  BIT_W  bits per frame; valid range 1..2^BIT_W-1.
REQ-008 Edge_Cnt  output  PRESC_W  edge position within current bit, registered.
REQ-009 Bit_Cnt  output  BIT_W  index of current bit in frame, registered.
REQ-010 Sample_Stb  output  3  mid-bit sample strobes, decoded from registered state.
REQ-011 Bit_Done  output  1  registered one-cycle pulse per completed bit.
REQ-012 Frame_Done  output  1  registered one-cycle pulse per completed frame.
REQ-013 Cfg_Err  output  1  registered flag; configuration invalid while EN high.

Function
REQ-014 Block SHALL implement states IDLE, COUNT, DONE.
REQ-015 IDLE: Edge_Cnt=0, Bit_Cnt=0, all pulses and strobes 0.
REQ-016 IDLE, EN=1, config valid: latch PRESCALE->P and FRAME_BITS->F; next state COUNT with Edge_Cnt=0, Bit_Cnt=0.
REQ-017 IDLE, EN=1, config invalid (PRESCALE<4 or FRAME_BITS=0): remain IDLE; Cfg_Err=1 the following cycle; Cfg_Err clears the cycle after EN falls or config becomes valid.
REQ-018 COUNT: Edge_Cnt SHALL increment by 1 each cycle; when Edge_Cnt==P-1 it wraps to 0 and Bit_Cnt increments.
REQ-019 Edge comparison SHALL be done on P-1 (no Edge_Cnt+1 overflow); PRESCALE=2^PRESC_W-1 SHALL work.
REQ-020 Bit_Done SHALL be high exactly the cycle after each wrap, i.e. coincident with Edge_Cnt=0 of the next bit or with DONE entry.
REQ-021 Wrap with Bit_Cnt==F-1: next state DONE; Bit_Cnt=F, Edge_Cnt=0; Bit_Done and Frame_Done both high that cycle.
REQ-022 DONE: counters hold; no strobes or pulses; stays while EN=1; a new frame requires EN low for at least one cycle.
REQ-023 EN=0 in any state: next cycle IDLE, counters 0; Frame_Done not asserted for an aborted frame.
REQ-024 PRESCALE/FRAME_BITS changes after latching SHALL be ignored until the next IDLE->COUNT transition.
REQ-025 Sample_Stb[1] SHALL be high in COUNT when Edge_Cnt==(P>>1)-1.
REQ-026 Each Sample_Stb bit SHALL be high at most once per bit period.

Reset
REQ-027 On RST low: state IDLE, Edge_Cnt=0, Bit_Cnt=0, Bit_Done=0, Frame_Done=0, Cfg_Err=0, P and F latches 0, immediately and independent of CLK.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no Frame_Done; after release, block waits in IDLE for EN.

Configuration
REQ-029 Macro EDGE_BIT_TIMER_SAMPLE3_EN SHALL select majority-vote sampling.
REQ-030 Defined: Sample_Stb[0] at Edge_Cnt==(P>>1)-2, [1] at (P>>1)-1, [2] at (P>>1), all in COUNT only.
REQ-031 Undefined: Sample_Stb[0] and Sample_Stb[2] SHALL be constant 0; Sample_Stb[1] per REQ-025.

Verification
REQ-032 PRESCALE=8, FRAME_BITS=10, EN held high -> 80 COUNT cycles; 10 Bit_Done pulses 8 cycles apart; Frame_Done with the 10th; DONE with Bit_Cnt=10.
REQ-033 PRESCALE=8, SAMPLE3 defined -> Sample_Stb[0]/[1]/[2] at Edge_Cnt=2/3/4 each bit; undefined -> only Sample_Stb[1] at Edge_Cnt=3.
REQ-034 EN low at Bit_Cnt=5, Edge_Cnt=3 -> next cycle IDLE, Edge_Cnt=0, Bit_Cnt=0, no Frame_Done.
REQ-035 PRESCALE=3 with EN high -> Cfg_Err=1 next cycle; no counting; PRESCALE changed to 16 -> Cfg_Err clears, COUNT entered.
REQ-036 PRESCALE=63, FRAME_BITS=15 -> Edge_Cnt reaches 62 then wraps; Frame_Done after 945 COUNT cycles.
REQ-037 PRESCALE changed 8->16 mid-frame, then RST pulsed low at Bit_Cnt=2 -> bit period stays 8 until reset; after reset all outputs 0, IDLE.
